// File: rtl/ir_cmd_ctrl_if.sv
// Receiver-to-controller strobes and the controller-to-consumer command handshake.
interface ir_cmd_ctrl_if;
    logic        frame_valid;
    logic [31:0] frame;
    logic        repeat_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_code;
    logic        cmd_repeat;

    modport master (
        output frame_valid, frame, repeat_valid, cmd_ready,
        input  cmd_valid, cmd_addr, cmd_code, cmd_repeat
    );

    modport slave (
        input  frame_valid, frame, repeat_valid, cmd_ready,
        output cmd_valid, cmd_addr, cmd_code, cmd_repeat
    );
endinterface

// File: rtl/ir_cmd_ctrl.sv
// NEC command controller: frame validation, key-hold tracking with rate-divided
// auto-repeat, and a first-word-fall-through command FIFO.
module ir_cmd_ctrl #(
    parameter int HOLD_TIMEOUT_CYCLES = 12_000_000,
    parameter int REPEAT_DIV          = 2,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic          clk,
    input  logic          rst,
    ir_cmd_ctrl_if.slave  bus,
    output logic          key_held,
    output logic          key_release,
    output logic [7:0]    err_cnt,
    output logic [7:0]    drop_cnt
);
    localparam int TMR_W = $clog2(HOLD_TIMEOUT_CYCLES + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, HELD} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         rpt_cnt_q, rpt_cnt_d;
    logic [7:0]         last_addr_q, last_addr_d;
    logic [7:0]         last_cmd_q, last_cmd_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [7:0]         drop_cnt_q;
    logic               release_q, release_d;
    logic               push;
    logic [16:0]        push_data;
    logic               frame_ok;

    logic [16:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               pop, push_ok, fifo_full;

    assign frame_ok = (bus.frame[15:8] == ~bus.frame[7:0]) &&
                      (bus.frame[31:24] == ~bus.frame[23:16]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            rpt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            release_q   <= 1'b0;
            last_addr_q <= '0;
            last_cmd_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rpt_cnt_q   <= rpt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            release_q   <= release_d;
            last_addr_q <= last_addr_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    // A frame always wins over a repeat strobe arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rpt_cnt_d   = rpt_cnt_q;
        last_addr_d = last_addr_q;
        last_cmd_d  = last_cmd_q;
        err_cnt_d   = err_cnt_q;
        release_d   = 1'b0;
        push        = 1'b0;
        push_data   = '0;
        if (bus.frame_valid) begin
            timer_d = '0;
            if (frame_ok) begin
                push        = 1'b1;
                push_data   = {1'b0, bus.frame[7:0], bus.frame[23:16]};
                last_addr_d = bus.frame[7:0];
                last_cmd_d  = bus.frame[23:16];
                rpt_cnt_d   = '0;
                state_d     = HELD;
            end else begin
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                state_d = IDLE;
            end
        end else if (state_q == HELD) begin
            if (bus.repeat_valid) begin
                timer_d = '0;
                if (rpt_cnt_q == 8'(REPEAT_DIV - 1)) begin
                    push      = 1'b1;
                    push_data = {1'b1, last_addr_q, last_cmd_q};
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 8'd1;
                end
            end else if (timer_q == TMR_W'(HOLD_TIMEOUT_CYCLES - 1)) begin
                timer_d   = '0;
                state_d   = IDLE;
                release_d = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = (count_q != '0) && bus.cmd_ready;
    assign push_ok   = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push_ok) count_q <= count_q - CNT_W'(1);
            if (push && !push_ok && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // Storage carries data only; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign bus.cmd_valid  = (count_q != '0);
    assign bus.cmd_repeat = bus.cmd_valid ? mem[rd_ptr_q][16]   : 1'b0;
    assign bus.cmd_addr   = bus.cmd_valid ? mem[rd_ptr_q][15:8] : 8'h00;
    assign bus.cmd_code   = bus.cmd_valid ? mem[rd_ptr_q][7:0]  : 8'h00;

    assign key_held    = (state_q == HELD);
    assign key_release = release_q;
    assign err_cnt     = err_cnt_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Directed bench for ir_cmd_ctrl with a short hold timeout and a 4-entry FIFO.
module tb_ir_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_held, key_release;
    logic [7:0] err_cnt, drop_cnt;
    int         passed = 0;
    int         total  = 0;

    ir_cmd_ctrl_if bus();

    ir_cmd_ctrl #(
        .HOLD_TIMEOUT_CYCLES(100),
        .REPEAT_DIV(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .key_held(key_held),
        .key_release(key_release),
        .err_cnt(err_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    initial begin
        int held_cycles, rel_cycles, rpt_seen;
        logic [7:0] order [4];

        bus.frame_valid  = 1'b0;
        bus.frame        = '0;
        bus.repeat_valid = 1'b0;
        bus.cmd_ready    = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_addr", bus.cmd_addr, 0);
        check("rst_held", key_held, 0);
        check("rst_err", err_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_release", key_release, 0);

        // Single valid frame
        bus.cmd_ready   = 1'b1;
        bus.frame       = 32'hF708FB04;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        check("f1_valid", bus.cmd_valid, 1);
        check("f1_addr", bus.cmd_addr, 8'h04);
        check("f1_code", bus.cmd_code, 8'h08);
        check("f1_repeat", bus.cmd_repeat, 0);
        check("f1_held", key_held, 1);
        step();
        check("f1_popped", bus.cmd_valid, 0);

        // Four repeat codes at REPEAT_DIV=2 give two repeat commands
        rpt_seen = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.repeat_valid = 1'b1;
            step();
            bus.repeat_valid = 1'b0;
            check("rpt_valid", bus.cmd_valid, (i % 2 == 0) ? 1 : 0);
            if (bus.cmd_valid) begin
                rpt_seen++;
                check("rpt_addr", bus.cmd_addr, 8'h04);
                check("rpt_code", bus.cmd_code, 8'h08);
                check("rpt_flag", bus.cmd_repeat, 1);
            end
            step();
            step();
        end
        check("rpt_count", rpt_seen, 2);

        // Hold timeout: 100 cycles after the frame edge
        bus.frame       = mk(8'h21, 8'h42);
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        held_cycles = 0;
        rel_cycles  = 0;
        for (int k = 1; k <= 99; k++) begin
            step();
            if (key_held) held_cycles++;
            if (key_release) rel_cycles++;
        end
        check("to_held99", held_cycles, 99);
        check("to_norel", rel_cycles, 0);
        step();
        check("to_dropped", key_held, 0);
        check("to_release", key_release, 1);
        step();
        check("to_release_once", key_release, 0);
        bus.repeat_valid = 1'b1;
        step();
        bus.repeat_valid = 1'b0;
        check("idle_rpt", bus.cmd_valid, 0);
        bus.repeat_valid = 1'b1;
        step();
        bus.repeat_valid = 1'b0;
        check("idle_rpt2", bus.cmd_valid, 0);

        // Bad complement frames
        bus.frame       = 32'hF708FB05;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        check("bad_err", err_cnt, 1);
        check("bad_noenq", bus.cmd_valid, 0);
        check("bad_held", key_held, 0);
        bus.frame_valid = 1'b1;
        for (int i = 0; i < 299; i++) step();
        bus.frame_valid = 1'b0;
        check("bad_sat", err_cnt, 8'hFF);

        // Overflow with the consumer stalled
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.frame       = mk(8'h10 + 8'(i), 8'h20 + 8'(i));
            bus.frame_valid = 1'b1;
            step();
        end
        bus.frame_valid = 1'b0;
        check("ovf_drop", drop_cnt, 2);
        check("ovf_head", bus.cmd_addr, 8'h10);
        // Push and pop together while full
        bus.cmd_ready   = 1'b1;
        bus.frame       = mk(8'h30, 8'h40);
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        bus.cmd_ready   = 1'b0;
        check("pp_drop", drop_cnt, 2);
        check("pp_head", bus.cmd_addr, 8'h11);
        bus.frame       = mk(8'h50, 8'h60);
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        check("pp_still_full", drop_cnt, 3);
        order[0] = 8'h11; order[1] = 8'h12; order[2] = 8'h13; order[3] = 8'h30;
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus.cmd_valid, 1);
            check("drain_addr", bus.cmd_addr, order[i]);
            check("drain_code", bus.cmd_code, order[i] == 8'h30 ? 8'h40 : order[i] + 8'h10);
            step();
        end
        check("drain_empty", bus.cmd_valid, 0);

        // Reset mid-HELD with pending entries
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.frame       = mk(8'h70 + 8'(i), 8'h01);
            bus.frame_valid = 1'b1;
            step();
        end
        bus.frame_valid = 1'b0;
        check("pre_rst_held", key_held, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", bus.cmd_valid, 0);
        check("mrst_held", key_held, 0);
        check("mrst_err", err_cnt, 0);
        check("mrst_drop", drop_cnt, 0);
        check("mrst_code", bus.cmd_code, 0);
        check("mrst_rel", key_release, 0);
        step();
        check("mrst_rel2", key_release, 0);

        // Frame and repeat together: only the frame counts
        bus.frame       = mk(8'hA1, 8'hB1);
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid  = 1'b0;
        bus.repeat_valid = 1'b1;
        step();
        bus.frame        = mk(8'hA2, 8'hB2);
        bus.frame_valid  = 1'b1;
        step();
        bus.frame_valid  = 1'b0;
        bus.repeat_valid = 1'b0;
        bus.cmd_ready    = 1'b1;
        check("both_a_addr", bus.cmd_addr, 8'hA1);
        check("both_a_rep", bus.cmd_repeat, 0);
        step();
        check("both_b_addr", bus.cmd_addr, 8'hA2);
        check("both_b_rep", bus.cmd_repeat, 0);
        step();
        check("both_empty", bus.cmd_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ir_cmd_ctrl.md
Name: ir_cmd_ctrl

Overview:
NEC command controller between the IR frame receiver and the application logic.
- Takes raw 32-bit frames and repeat-code pulses from the receiver.
- Validates the address and command complement bytes.
- Tracks key-held state with a hold timeout and turns repeat codes into rate-divided auto-repeat commands.
- Buffers decoded commands in a small FWFT FIFO with a valid/ready consumer handshake.

Parameters:
HOLD_TIMEOUT_CYCLES, 12_000_000, cycles without a frame or repeat before the held key is released (120 ms at 100 MHz)
REPEAT_DIV, 2, emit one repeat command per REPEAT_DIV accepted repeat codes; legal range 1..255
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
frame_valid  in  1  one-cycle strobe: frame holds a new received frame
frame  in  32  LSB-first NEC frame: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
repeat_valid  in  1  one-cycle strobe: receiver saw a repeat code
cmd_valid  out  1  FIFO head valid (FIFO not empty)
cmd_ready  in  1  consumer accepts the head when high together with cmd_valid
cmd_addr  out  8  head entry address
cmd_code  out  8  head entry command
cmd_repeat  out  1  head entry was generated by a repeat code
key_held  out  1  high while state is HELD
key_release  out  1  one-cycle pulse on the HELD->IDLE timeout
err_cnt  out  8  count of frames failing the complement check; saturates at 255
drop_cnt  out  8  count of enqueues lost because the FIFO was full; saturates at 255

Behaviour:
Reset:
- Applies on any clk edge with rst=1.
- Clears the FIFO (cmd_valid=0), the state (IDLE), the hold timer, rpt_cnt, err_cnt, drop_cnt and key_release.
- cmd_addr, cmd_code and cmd_repeat read 0.
- Reset mid-FIFO or mid-HELD discards all pending data. No key_release pulse is generated.

Frame check (combinational on frame): ok = (frame[15:8] == ~frame[7:0]) && (frame[31:24] == ~frame[23:16]).

State machine (IDLE, HELD):
- frame_valid in any state, ok=1:
  - enqueue {repeat=0, addr=frame[7:0], cmd=frame[23:16]}
  - latch last_addr and last_cmd
  - timer=0, rpt_cnt=0, go to HELD
- frame_valid, ok=0:
  - err_cnt+1 (saturating)
  - go to IDLE, no key_release pulse, nothing enqueued
- repeat_valid in HELD:
  - timer=0
  - if rpt_cnt == REPEAT_DIV-1: enqueue {1, last_addr, last_cmd} and set rpt_cnt=0
  - otherwise rpt_cnt+1
- repeat_valid in IDLE: ignored; no counter changes.
- frame_valid and repeat_valid in the same cycle: the frame is processed, the repeat is ignored.
- HELD with no event:
  - timer+1
  - at timer == HOLD_TIMEOUT_CYCLES-1: go to IDLE and pulse key_release for exactly one cycle
  - the timer is wide enough to hold HOLD_TIMEOUT_CYCLES and never wraps

FIFO:
- First-word-fall-through. cmd_addr, cmd_code and cmd_repeat show the head whenever cmd_valid=1.
- Pop when cmd_valid && cmd_ready.
- Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged.
- Push into a full FIFO with no pop: entry dropped, drop_cnt+1 (saturating). FIFO contents are untouched.
- Pop on an empty FIFO: no effect.
- Pointers wrap modulo FIFO_DEPTH.

Latency:
- frame_valid or repeat_valid at edge N gives cmd_valid=1 after edge N, provided the FIFO was empty.
- key_held follows the state register with no added latency.

Test Plan:
- Reset, then frame=0xF708FB04 with frame_valid, cmd_ready=1 -> next cycle cmd_valid=1, cmd_addr=0x04, cmd_code=0x08, cmd_repeat=0; key_held=1.
- REPEAT_DIV=2: after a valid frame, 4 repeat_valid pulses spaced well inside the timeout, cmd_ready=1 -> exactly 2 repeat commands {0x04, 0x08, repeat=1}, one after the 2nd pulse and one after the 4th.
- Valid frame then idle, small HOLD_TIMEOUT_CYCLES=100 -> key_held falls exactly 100 cycles after the frame edge, with one key_release pulse; a later repeat_valid enqueues nothing.
- frame=0xF708FB05 (bad addr complement) -> err_cnt=1, nothing enqueued, key_held=0; drive 300 bad frames -> err_cnt holds at 255.
- cmd_ready=0, FIFO_DEPTH=4, 6 valid frames -> 4 entries kept in order, drop_cnt=2. Raise cmd_ready -> 4 pops in arrival order, then cmd_valid=0. Push and pop in the same cycle while full -> accepted, count stays 4.
- Mid-HELD with 3 FIFO entries, assert rst for one cycle -> cmd_valid=0, key_held=0, counters 0, no key_release pulse. frame_valid and repeat_valid together -> only the frame entry is enqueued.
